// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared HWPE stream types: address generator job descriptor, flags and 3D state
package hwpe_stream_package;

   // Job descriptor for the strided address generators. Strides are two's complement.
   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] tot_len;
      logic [31:0] d0_len;
      logic [31:0] d0_stride;
      logic [31:0] d1_len;
      logic [31:0] d1_stride;
      logic [31:0] d2_stride;
      logic [1:0]  dim_enable_1h;
   } ctrl_addressgen_v3_t;

   typedef struct packed {
      logic done;
   } flags_addressgen_v3_t;

   typedef enum logic [1:0] {
      AG3D_IDLE,
      AG3D_RUN,
      AG3D_DONE
   } state_addrgen_3d_t;

endpackage

// File: rtl/hwpe_stream_addrgen_3d.sv
// rtl/hwpe_stream_addrgen_3d.sv - three-dimensional strided word address generator
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         synchronous soft clear, same effect as reset
//   start_i, ctrl_i job start (honoured in IDLE only) and descriptor latched with it
//   addr_o          registered byte address of the current word
//   addr_valid_o    addr_o valid; addr_ready_i consumer accepts it
//   busy_o          job in progress (RUN or DONE)
//   flags_o.done    one-cycle pulse at job end
module hwpe_stream_addrgen_3d
   import hwpe_stream_package::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  ctrl_addressgen_v3_t  ctrl_i,
   output logic [31:0]          addr_o,
   output logic                 addr_valid_o,
   input  logic                 addr_ready_i,
   output logic                 busy_o,
   output flags_addressgen_v3_t flags_o
);

   state_addrgen_3d_t   state;
   ctrl_addressgen_v3_t cfg;

   logic [31:0] d0_acc, d1_acc, d2_acc;
   logic [31:0] d0_cnt, d1_cnt, word_cnt;

   logic [31:0] d0_acc_n, d1_acc_n, d2_acc_n;
   logic [31:0] d0_cnt_n, d1_cnt_n;
   logic [31:0] addr_n;
   logic        d0_wrap, d1_wrap;
   logic        handshake, last_word;

   assign handshake = addr_valid_o & addr_ready_i;
   assign last_word = (word_cnt == cfg.tot_len - 32'd1);

   // Next counter/accumulator values for the word after the one being handed over.
   // The address adder sits here so addr_o is loaded already summed, keeping
   // one address per cycle across wraps.
   always_comb begin
      d0_wrap  = cfg.dim_enable_1h[0] && (cfg.d0_len != 32'd0) &&
                 (d0_cnt == cfg.d0_len - 32'd1);
      d1_wrap  = cfg.dim_enable_1h[1] && (cfg.d1_len != 32'd0) &&
                 (d1_cnt == cfg.d1_len - 32'd1);
      d0_acc_n = d0_acc;
      d1_acc_n = d1_acc;
      d2_acc_n = d2_acc;
      d0_cnt_n = d0_cnt;
      d1_cnt_n = d1_cnt;
      if (!d0_wrap) begin
         d0_cnt_n = d0_cnt + 32'd1;
         d0_acc_n = d0_acc + cfg.d0_stride;
      end else begin
         d0_cnt_n = 32'd0;
         d0_acc_n = 32'd0;
         if (d1_wrap) begin
            d1_cnt_n = 32'd0;
            d1_acc_n = 32'd0;
            d2_acc_n = d2_acc + cfg.d2_stride;
         end else begin
            d1_cnt_n = d1_cnt + 32'd1;
            d1_acc_n = d1_acc + cfg.d1_stride;
         end
      end
      addr_n = cfg.base_addr + d2_acc_n + d1_acc_n + d0_acc_n;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state        <= AG3D_IDLE;
         cfg          <= '0;
         d0_acc       <= 32'd0;
         d1_acc       <= 32'd0;
         d2_acc       <= 32'd0;
         d0_cnt       <= 32'd0;
         d1_cnt       <= 32'd0;
         word_cnt     <= 32'd0;
         addr_o       <= 32'd0;
         addr_valid_o <= 1'b0;
         busy_o       <= 1'b0;
         flags_o      <= '0;
      end else begin
         flags_o.done <= 1'b0;
         case (state)
            AG3D_IDLE: begin
               if (start_i) begin
                  d0_acc   <= 32'd0;
                  d1_acc   <= 32'd0;
                  d2_acc   <= 32'd0;
                  d0_cnt   <= 32'd0;
                  d1_cnt   <= 32'd0;
                  word_cnt <= 32'd0;
                  busy_o   <= 1'b1;
                  if (ctrl_i.tot_len != 32'd0) begin
                     cfg          <= ctrl_i;
                     addr_o       <= ctrl_i.base_addr;
                     addr_valid_o <= 1'b1;
                     state        <= AG3D_RUN;
                  end else begin
                     flags_o.done <= 1'b1;
                     state        <= AG3D_DONE;
                  end
               end
            end
            AG3D_RUN: begin
               if (handshake) begin
                  if (last_word) begin
                     addr_valid_o <= 1'b0;
                     flags_o.done <= 1'b1;
                     state        <= AG3D_DONE;
                  end else begin
                     d0_acc   <= d0_acc_n;
                     d1_acc   <= d1_acc_n;
                     d2_acc   <= d2_acc_n;
                     d0_cnt   <= d0_cnt_n;
                     d1_cnt   <= d1_cnt_n;
                     word_cnt <= word_cnt + 32'd1;
                     addr_o   <= addr_n;
                  end
               end
            end
            AG3D_DONE: begin
               busy_o <= 1'b0;
               state  <= AG3D_IDLE;
            end
            default: begin
               state <= AG3D_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hwpe_stream_addrgen_3d.sv
// tb/tb_hwpe_stream_addrgen_3d.sv - self-checking bench for hwpe_stream_addrgen_3d
module tb_hwpe_stream_addrgen_3d;
   import hwpe_stream_package::*;

   logic                 clk;
   logic                 rst_n;
   logic                 clear;
   logic                 start;
   ctrl_addressgen_v3_t  ctrl;
   logic [31:0]          addr;
   logic                 valid;
   logic                 ready;
   logic                 busy;
   flags_addressgen_v3_t flags;

   int checks;
   int failures;

   ctrl_addressgen_v3_t cfg_m;
   logic [31:0]         got_q[$];
   logic [31:0]         stall_q[$];
   logic [31:0]         exp_a[8];

   int first_v, last_hs, done_cyc, done_cnt, hs_cnt;

   hwpe_stream_addrgen_3d dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .start_i      (start),
      .ctrl_i       (ctrl),
      .addr_o       (addr),
      .addr_valid_o (valid),
      .addr_ready_i (ready),
      .busy_o       (busy),
      .flags_o      (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Word k of the job, from its position in the (d0, d1, d2) iteration space.
   function automatic logic [31:0] model_addr(input int k);
      logic [31:0] i0, i1, i2, q, kk;
      kk = k;
      i1 = 32'd0;
      i2 = 32'd0;
      if (cfg_m.dim_enable_1h[0] && cfg_m.d0_len != 0) begin
         i0 = kk % cfg_m.d0_len;
         q  = kk / cfg_m.d0_len;
         if (cfg_m.dim_enable_1h[1] && cfg_m.d1_len != 0) begin
            i1 = q % cfg_m.d1_len;
            i2 = q / cfg_m.d1_len;
         end else begin
            i1 = q;
         end
      end else begin
         i0 = kk;
      end
      return cfg_m.base_addr + i0 * cfg_m.d0_stride + i1 * cfg_m.d1_stride
             + i2 * cfg_m.d2_stride;
   endfunction

   function automatic ctrl_addressgen_v3_t mk(input logic [31:0] base, input logic [31:0] tot,
                                               input logic [31:0] l0, input logic [31:0] s0,
                                               input logic [31:0] l1, input logic [31:0] s1,
                                               input logic [31:0] s2, input logic [1:0] dim);
      ctrl_addressgen_v3_t c;
      c.base_addr     = base;
      c.tot_len       = tot;
      c.d0_len        = l0;
      c.d0_stride     = s0;
      c.d1_len        = l1;
      c.d1_stride     = s1;
      c.d2_stride     = s2;
      c.dim_enable_1h = dim;
      return c;
   endfunction

   // Every cycle with a valid address is checked against the model.
   task automatic compare_loop();
      int idx;
      idx = 0;
      forever begin
         @(negedge clk);
         if (valid) begin
            if (idx >= int'(cfg_m.tot_len))
               check("word_index", idx, cfg_m.tot_len - 32'd1);
            else
               check("model_addr", addr, model_addr(idx));
            if (ready) idx++;
         end
         if (!rst_n || clear || (start && !busy)) idx = 0;
      end
   endtask

   // Called at posedge+2; returns at posedge+2 of the cycle after the done pulse.
   task automatic run_job(input string name, input ctrl_addressgen_v3_t c,
                          input int stall_at, input int stall_len, input int poke_at);
      int  rel, stalled;
      bit  fin;
      cfg_m = c;
      got_q.delete();
      stall_q.delete();
      ctrl  = c;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #2;
      start    = 1'b0;
      rel      = 1;
      stalled  = 0;
      fin      = 1'b0;
      hs_cnt   = 0;
      first_v  = -1;
      last_hs  = -1;
      done_cyc = -1;
      done_cnt = 0;
      while (!fin && rel < 200) begin
         if (stall_at == hs_cnt && stalled < stall_len) begin
            ready = 1'b0;
            stalled++;
         end else begin
            ready = 1'b1;
         end
         if (rel == poke_at) begin
            start = 1'b1;
            ctrl  = '1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (valid && first_v < 0) first_v = rel;
         if (valid && !ready) stall_q.push_back(addr);
         if (valid && ready) begin
            got_q.push_back(addr);
            hs_cnt++;
            last_hs = rel;
         end
         if (flags.done) begin
            done_cnt++;
            done_cyc = rel;
            check({name, "_valid_at_done"}, valid, 0);
            check({name, "_busy_at_done"}, busy, 1);
            fin = 1'b1;
         end
         @(posedge clk); #2;
         rel++;
      end
      start = 1'b0;
      check({name, "_terminated"}, fin, 1);
      check({name, "_hs_count"}, hs_cnt, c.tot_len);
      check({name, "_done_count"}, done_cnt, 1);
      if (c.tot_len != 0) begin
         check({name, "_first_valid"}, first_v, 1);
         check({name, "_no_bubbles"}, last_hs, first_v + int'(c.tot_len) - 1 + stall_len);
         check({name, "_done_cycle"}, done_cyc, last_hs + 1);
      end else begin
         check({name, "_first_valid"}, first_v, -1);
         check({name, "_done_cycle"}, done_cyc, 1);
      end
   endtask

   task automatic check_seq(input string name, input int n);
      check({name, "_len"}, got_q.size(), n);
      for (int i = 0; i < n; i++)
         if (i < got_q.size()) check($sformatf("%s_w%0d", name, i), got_q[i], exp_a[i]);
   endtask

   // Start a job, let two words through, then clear or reset it.
   task automatic abort_job(input string name, input ctrl_addressgen_v3_t c, input bit use_rst);
      int n, v_cnt, d_cnt;
      cfg_m = c;
      ctrl  = c;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         @(negedge clk);
         if (valid && ready) n++;
         @(posedge clk); #2;
      end
      check({name, "_two_words"}, n, 2);
      if (use_rst) rst_n = 1'b0; else clear = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b1;
      clear = 1'b0;
      @(negedge clk);
      check({name, "_valid_drop"}, valid, 0);
      check({name, "_busy_drop"}, busy, 0);
      check({name, "_addr_zero"}, addr, 0);
      v_cnt = 0;
      d_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (valid) v_cnt++;
         if (flags.done) d_cnt++;
         @(negedge clk);
      end
      check({name, "_no_valid"}, v_cnt, 0);
      check({name, "_no_done"}, d_cnt, 0);
      @(posedge clk); #2;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clear    = 1'b0;
      start    = 1'b0;
      ready    = 1'b0;
      ctrl     = '0;
      cfg_m    = '0;
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_addr", addr, 0);
      check("reset_valid", valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", flags.done, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      run_job("1d", mk(32'h1000, 4, 0, 4, 0, 0, 0, 2'b00), -1, 0, -1);
      exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0};
      check_seq("1d", 4);

      run_job("2d", mk(0, 6, 3, 4, 0, 32'h100, 0, 2'b01), -1, 0, -1);
      exp_a = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108, 0, 0};
      check_seq("2d", 6);

      run_job("3d", mk(0, 8, 2, 4, 2, 32'h10, 32'h1000, 2'b11), -1, 0, -1);
      exp_a = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h1000, 32'h1004, 32'h1010, 32'h1014};
      check_seq("3d", 8);

      run_job("neg", mk(32'h4, 3, 0, 32'hFFFFFFFC, 0, 0, 0, 2'b00), 1, 3, -1);
      exp_a = '{32'h4, 32'h0, 32'hFFFFFFFC, 0, 0, 0, 0, 0};
      check_seq("neg", 3);
      check("neg_stall_len", stall_q.size(), 3);
      foreach (stall_q[i]) check($sformatf("neg_stall_hold%0d", i), stall_q[i], 32'h0);

      run_job("zero", mk(32'h2000, 0, 0, 4, 0, 0, 0, 2'b00), -1, 0, -1);

      run_job("poke", mk(32'h1000, 4, 0, 4, 0, 0, 0, 2'b00), -1, 0, 2);
      exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0};
      check_seq("poke", 4);

      abort_job("clr", mk(0, 6, 3, 4, 0, 32'h100, 0, 2'b01), 1'b0);
      run_job("clr_re", mk(0, 6, 3, 4, 0, 32'h100, 0, 2'b01), -1, 0, -1);
      exp_a = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108, 0, 0};
      check_seq("clr_re", 6);

      abort_job("rst", mk(0, 6, 3, 4, 0, 32'h100, 0, 2'b01), 1'b1);
      run_job("rst_re", mk(0, 6, 3, 4, 0, 32'h100, 0, 2'b01), -1, 0, -1);
      check_seq("rst_re", 6);

      @(negedge clk);
      check("idle_valid", valid, 0);
      check("idle_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
